// File: rtl/i2c_eeprom_slave_pkg.sv
// Shared types for the I2C EEPROM responder: FSM state encoding and small helpers.
package i2c_eeprom_slave_pkg;

    typedef enum logic [3:0] {
        S_IDLE     = 4'd0,
        S_DEV_ADDR = 4'd1,
        S_DEV_ACK  = 4'd2,
        S_REG_ADDR = 4'd3,
        S_REG_ACK  = 4'd4,
        S_WR_DATA  = 4'd5,
        S_WR_ACK   = 4'd6,
        S_RD_DATA  = 4'd7,
        S_RD_ACK   = 4'd8,
        S_IGNORE   = 4'd9
    } state_t;

    // Busy only once our address has matched, so a transfer to another device never raises it.
    function automatic logic is_addressed(input state_t s);
        return !(s == S_IDLE || s == S_IGNORE || s == S_DEV_ADDR);
    endfunction

endpackage

// File: rtl/i2c_eeprom_slave_bus_sync.sv
// Synchronises SCL/SDA into clk and derives SCL edges plus START/STOP conditions.
module i2c_bus_sync (
    input  logic clk,
    input  logic reset_n,
    input  logic scl_in,
    input  logic sda_in,
    output logic scl_rise,
    output logic scl_fall,
    output logic start_det,
    output logic stop_det,
    output logic sda_s
);

    // [0] metastability flop, [1] synchronised value, [2] history for edge detection
    logic [2:0] scl_r;
    logic [2:0] sda_r;

    // Two-flop synchronisers plus one history stage, idle-high after reset
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            scl_r <= 3'b111;
            sda_r <= 3'b111;
        end else begin
            scl_r <= {scl_r[1:0], scl_in};
            sda_r <= {sda_r[1:0], sda_in};
        end
    end

    assign sda_s     = sda_r[1];
    assign scl_rise  = scl_r[1] & ~scl_r[2];
    assign scl_fall  = ~scl_r[1] & scl_r[2];
    assign start_det = scl_r[1] & scl_r[2] & sda_r[2] & ~sda_r[1];
    assign stop_det  = scl_r[1] & scl_r[2] & ~sda_r[2] & sda_r[1];

endmodule

// File: rtl/i2c_eeprom_slave.sv
// I2C responder emulating a byte-addressed EEPROM with an auto-incrementing pointer.
module i2c_eeprom_slave
    import i2c_eeprom_slave_pkg::*;
#(
    parameter logic [6:0] DEV_ADDR = 7'h50,
    parameter int         ADDR_W   = 8,
    parameter logic [7:0] MEM_INIT = 8'hFF
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              i2c_scl_i,
    inout  wire               i2c_sda,
    output logic              i2c_sda_en,
    output logic              busy,
    output logic              wr_valid,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [7:0]        wr_data
);

    localparam int                DEPTH   = 2 ** ADDR_W;
    localparam logic [ADDR_W-1:0] PTR_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};

    state_t            state_r, state_nxt;
    logic [2:0]        bit_cnt_r, bit_cnt_nxt;
    logic [7:0]        shreg_r, shreg_nxt;
    logic [ADDR_W-1:0] ptr_r, ptr_nxt;
    logic              sda_en_nxt;
    logic              mem_we;
    logic [7:0]        mem_r [DEPTH];
    logic [7:0]        rx_byte;
    logic [7:0]        rd_byte;
    logic              scl_rise, scl_fall, start_det, stop_det, sda_s;

    assign i2c_sda = i2c_sda_en ? 1'b0 : 1'bz;

    i2c_bus_sync u_sync (
        .clk       (clk),
        .reset_n   (reset_n),
        .scl_in    (i2c_scl_i),
        .sda_in    (i2c_sda),
        .scl_rise  (scl_rise),
        .scl_fall  (scl_fall),
        .start_det (start_det),
        .stop_det  (stop_det),
        .sda_s     (sda_s)
    );

    assign rx_byte = {shreg_r[6:0], sda_s};
    assign rd_byte = mem_r[ptr_r];

    // Next-state logic; ACK states use sda_en itself to tell the first SCL fall from the second
    always_comb begin
        state_nxt   = state_r;
        bit_cnt_nxt = bit_cnt_r;
        shreg_nxt   = shreg_r;
        ptr_nxt     = ptr_r;
        sda_en_nxt  = i2c_sda_en;
        mem_we      = 1'b0;
        if (start_det) begin
            state_nxt   = S_DEV_ADDR;
            bit_cnt_nxt = 3'd0;
            sda_en_nxt  = 1'b0;
        end else if (stop_det) begin
            state_nxt  = S_IDLE;
            sda_en_nxt = 1'b0;
        end else begin
            case (state_r)
                S_DEV_ADDR, S_REG_ADDR, S_WR_DATA: begin
                    if (scl_rise) begin
                        shreg_nxt   = rx_byte;
                        bit_cnt_nxt = bit_cnt_r + 3'd1;
                        if (bit_cnt_r == 3'd7) begin
                            case (state_r)
                                S_DEV_ADDR: state_nxt = (rx_byte[7:1] == DEV_ADDR) ? S_DEV_ACK : S_IGNORE;
                                S_REG_ADDR: begin
                                    ptr_nxt   = rx_byte[ADDR_W-1:0];
                                    state_nxt = S_REG_ACK;
                                end
                                default: begin
                                    mem_we    = 1'b1;
                                    ptr_nxt   = ptr_r + PTR_ONE;
                                    state_nxt = S_WR_ACK;
                                end
                            endcase
                        end else begin
                            state_nxt = state_r;
                        end
                    end else begin
                        state_nxt = state_r;
                    end
                end
                S_DEV_ACK, S_REG_ACK, S_WR_ACK: begin
                    if (scl_fall) begin
                        bit_cnt_nxt = 3'd0;
                        if (!i2c_sda_en) begin
                            sda_en_nxt = 1'b1;
                        end else if (state_r == S_DEV_ACK && shreg_r[0]) begin
                            sda_en_nxt = ~rd_byte[7];
                            shreg_nxt  = {rd_byte[6:0], 1'b0};
                            state_nxt  = S_RD_DATA;
                        end else begin
                            sda_en_nxt = 1'b0;
                            state_nxt  = (state_r == S_DEV_ACK) ? S_REG_ADDR : S_WR_DATA;
                        end
                    end else begin
                        state_nxt = state_r;
                    end
                end
                S_RD_DATA: begin
                    if (scl_rise) begin
                        bit_cnt_nxt = bit_cnt_r + 3'd1;
                    end else if (scl_fall) begin
                        if (bit_cnt_r == 3'd0) begin
                            sda_en_nxt = 1'b0;
                            state_nxt  = S_RD_ACK;
                        end else begin
                            sda_en_nxt = ~shreg_r[7];
                            shreg_nxt  = {shreg_r[6:0], 1'b0};
                        end
                    end else begin
                        state_nxt = S_RD_DATA;
                    end
                end
                S_RD_ACK: begin
                    // Pointer advances for every byte sent; only an ACK continues the burst
                    if (scl_rise) begin
                        ptr_nxt   = ptr_r + PTR_ONE;
                        state_nxt = sda_s ? S_IGNORE : S_RD_ACK;
                    end else if (scl_fall) begin
                        sda_en_nxt  = ~rd_byte[7];
                        shreg_nxt   = {rd_byte[6:0], 1'b0};
                        bit_cnt_nxt = 3'd0;
                        state_nxt   = S_RD_DATA;
                    end else begin
                        state_nxt = S_RD_ACK;
                    end
                end
                default: state_nxt = state_r;
            endcase
        end
    end

    // Control registers and registered outputs
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r    <= S_IDLE;
            bit_cnt_r  <= 3'd0;
            shreg_r    <= 8'h00;
            ptr_r      <= {ADDR_W{1'b0}};
            i2c_sda_en <= 1'b0;
            busy       <= 1'b0;
            wr_valid   <= 1'b0;
            wr_addr    <= {ADDR_W{1'b0}};
            wr_data    <= 8'h00;
        end else begin
            state_r    <= state_nxt;
            bit_cnt_r  <= bit_cnt_nxt;
            shreg_r    <= shreg_nxt;
            ptr_r      <= ptr_nxt;
            i2c_sda_en <= sda_en_nxt;
            busy       <= is_addressed(state_nxt);
            wr_valid   <= mem_we;
            if (mem_we) begin
                wr_addr <= ptr_r;
                wr_data <= rx_byte;
            end else begin
                wr_addr <= wr_addr;
                wr_data <= wr_data;
            end
        end
    end

    // Storage array, reinitialised on every reset
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= MEM_INIT;
            end
        end else if (mem_we) begin
            mem_r[ptr_r] <= rx_byte;
        end else begin
            mem_r[ptr_r] <= mem_r[ptr_r];
        end
    end

endmodule
